// File: rtl/lcd_st_pkg.sv
// lcd_st_pkg: shared framing state and beat layout for the LCD streaming path
package lcd_st_pkg;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  localparam int BEAT_DATA_W = 8;
  localparam int BEAT_CHAN_W = 8;
  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_CHAN_W-1:0] channel;
    logic                   sop;
    logic                   eop;
  } beat_t;
endpackage

// File: rtl/lcd_st_skid_buffer.sv
// lcd_st_skid_buffer: two-entry registered ready/valid stage with registered in_ready
module lcd_st_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] r_main, r_skid;
  logic             r_main_v, r_skid_v, r_ready;
  logic             w_acc, w_pop;
  assign w_acc     = in_valid && r_ready;
  assign w_pop     = r_main_v && out_ready;
  assign in_ready  = r_ready;
  assign out_valid = r_main_v;
  assign out_data  = r_main;
  // main register feeds the output; skid catches the one beat accepted while stalled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b0;
    end else if (r_skid_v) begin
      if (w_pop) begin
        r_main   <= r_skid;
        r_skid_v <= 1'b0;
        r_ready  <= 1'b1;
      end
    end else if (w_acc && r_main_v && !w_pop) begin
      r_skid   <= in_data;
      r_skid_v <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_acc) begin
        r_main   <= in_data;
        r_main_v <= 1'b1;
      end else if (w_pop)
        r_main_v <= 1'b0;
    end
endmodule

// File: rtl/lcd_st_channel_adapter.sv
// lcd_st_channel_adapter: maps a narrow input channel onto an offset output channel, dropping out-of-range packets
module lcd_st_channel_adapter
  import lcd_st_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 1,
  parameter int OUT_CHAN_W  = 8,
  parameter int CHAN_OFFSET = 0,
  parameter int MAX_CHAN    = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      drop_count
);
  localparam int BW = DATA_W + OUT_CHAN_W + 2;
  state_t                r_state;
  logic [OUT_CHAN_W-1:0] r_chan;
  logic                  r_err;
  logic [CNT_W-1:0]      r_drop;
  logic [OUT_CHAN_W:0]   w_mapped;
  logic [OUT_CHAN_W-1:0] w_chan;
  logic                  w_legal, w_acc, w_fwd;
  logic [BW-1:0]         w_beat, w_obeat;
  assign w_mapped   = (OUT_CHAN_W+1)'(in_channel) + (OUT_CHAN_W+1)'(CHAN_OFFSET);
  assign w_legal    = !w_mapped[OUT_CHAN_W] && (w_mapped[OUT_CHAN_W-1:0] <= OUT_CHAN_W'(MAX_CHAN));
  assign w_acc      = in_valid && in_ready;
  assign w_fwd      = w_acc && (in_startofpacket ? w_legal : r_state == PASS);
  assign w_chan     = in_startofpacket ? w_mapped[OUT_CHAN_W-1:0] : r_chan;
  assign w_beat     = {in_data, w_chan, in_startofpacket, in_endofpacket};
  assign err_pulse  = r_err;
  assign drop_count = r_drop;
  assign {out_data, out_channel, out_startofpacket, out_endofpacket} = w_obeat;
  // framing FSM: SOP always starts a new packet; non-SOP beats only pass while in PASS
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_chan  <= '0;
      r_err   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_err <= w_acc && (in_startofpacket ? r_state != IDLE : r_state == IDLE);
      if (w_acc && in_startofpacket) begin
        r_state <= in_endofpacket ? IDLE : (w_legal ? PASS : DROP);
        if (w_legal)
          r_chan <= w_mapped[OUT_CHAN_W-1:0];
        else if (r_drop != '1)
          r_drop <= r_drop + 1'b1;
      end else if (w_acc && in_endofpacket)
        r_state <= IDLE;
    end
  lcd_st_skid_buffer #(.WIDTH(BW)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w_fwd),
    .in_ready  (in_ready),
    .in_data   (w_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_obeat)
  );
endmodule
